// File: rtl/ip_forward_seq.sv
// Sequential fully-connected forward engine: out = sat((sum(in*w) + bias) >>> FRAC_BITS).
// Define IP_FWD_RELU_EN to clamp negative results to zero in the BIAS stage.
//
// state | meaning
// IDLE  | in_ready high, waiting for an input transaction
// MAC   | one multiply-accumulate per cycle over idx = 0..WIDTH-1
// BIAS  | add shifted bias, rescale, saturate, load output registers
// DONE  | result held on out_data/out_id until out_ready
module ip_forward_seq #(
    parameter int WIDTH     = 8,
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 16,
    parameter int ID_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data [WIDTH],
    input  logic [DATA_W-1:0] weights [WIDTH],
    input  logic [DATA_W-1:0] bias,
    input  logic [ID_W-1:0]   in_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ID_W-1:0]   out_id
);

    localparam int IDX_W  = $clog2(WIDTH);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + IDX_W;
    localparam int SUM_W  = ACC_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - DATA_W){1'b0}}, 1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_DONE} state_t;

    state_t                    state;
    logic [DATA_W-1:0]         in_r [WIDTH];
    logic [DATA_W-1:0]         w_r [WIDTH];
    logic [DATA_W-1:0]         bias_r;
    logic [ID_W-1:0]           id_r;
    logic signed [ACC_W-1:0]   acc;
    logic [IDX_W-1:0]          idx;

    logic signed [PROD_W-1:0]  prod;
    logic signed [SUM_W-1:0]   bias_ext;
    logic signed [SUM_W-1:0]   sum;
    logic signed [SUM_W-1:0]   shifted;
    logic [DATA_W-1:0]         result;

    always_comb begin
        prod     = PROD_W'($signed(in_r[idx])) * PROD_W'($signed(w_r[idx]));
        bias_ext = SUM_W'($signed(bias_r));
        sum      = SUM_W'(acc) + (bias_ext <<< FRAC_BITS);
        shifted  = sum >>> FRAC_BITS;
        if (shifted > SAT_MAX)
            result = SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN)
            result = SAT_MIN[DATA_W-1:0];
        else
            result = shifted[DATA_W-1:0];
`ifdef IP_FWD_RELU_EN
        if (result[DATA_W-1])
            result = '0;
`else
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            acc       <= '0;
            idx       <= '0;
            bias_r    <= '0;
            id_r      <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                in_r[i] <= '0;
                w_r[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_r     <= in_data;
                        w_r      <= weights;
                        bias_r   <= bias;
                        id_r     <= in_id;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= S_BIAS;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_BIAS: begin
                    out_data  <= result;
                    out_id    <= id_r;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    // in_ready rises together with the handshake so the next accept can be the very next edge
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_forward_seq.sv
// Scoreboard bench for ip_forward_seq: stimulus pushes hand-computed results, a negedge monitor checks them.
module tb_ip_forward_seq;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data [WIDTH];
    logic [31:0] weights [WIDTH];
    logic [31:0] bias;
    logic [7:0]  in_id;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_id;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  id;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        prev_v = 1'b0;
    logic [31:0] hold_d;
    logic [7:0]  hold_id;

    ip_forward_seq #(.WIDTH(WIDTH), .DATA_W(32), .FRAC_BITS(16), .ID_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .weights(weights), .bias(bias), .in_id(in_id),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Monitor: compares on the first cycle of out_valid, then checks hold stability while stalled.
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out actual id=%h data=%h required no output", out_id, out_data);
                end else begin
                    chk("out_data", 64'(out_data), 64'(sb[0].data));
                    chk("out_id", 64'(out_id), 64'(sb[0].id));
                    chk("latency", 64'(cyc), 64'(sb[0].due));
                end
                hold_d  = out_data;
                hold_id = out_id;
                chk("in_ready_busy", 64'(in_ready), 64'(0));
            end else if (out_valid) begin
                chk("hold_data", 64'(out_data), 64'(hold_d));
                chk("hold_id", 64'(out_id), 64'(hold_id));
                chk("hold_in_ready", 64'(in_ready), 64'(0));
            end
            if (out_valid && out_ready && sb.size() > 0)
                void'(sb.pop_front());
            prev_v = out_valid;
        end
    end

    task automatic set_all(input logic [31:0] iv, input logic [31:0] wv);
        for (int i = 0; i < WIDTH; i++) begin
            in_data[i] = iv;
            weights[i] = wv;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] b, input logic [7:0] id, input logic [31:0] exp_d);
        int n;
        bias     = b;
        in_id    = id;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual in_ready=0 required in_ready=1 id=%h", id);
        end
        @(posedge clk);
        @(negedge clk);
        sb.push_back('{data: exp_d, id: id, due: cyc + LAT});
        in_valid = 1'b0;
        set_all(32'hDEADBEEF, 32'hDEADBEEF);
        bias  = 32'hDEADBEEF;
        in_id = 8'hEE;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL result_timeout actual pending=%0d required pending=0", sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bias      = '0;
        in_id     = '0;
        set_all(32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_id", 64'(out_id), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        // 1.0 * 2.0 * 8 + 0.5 = 16.5
        set_all(32'h0001_0000, 32'h0002_0000);
        issue(32'h0000_8000, 8'h5A, 32'h0010_8000);
        wait_idle();

        // in[i] = i, w = 1.0, bias = -1.0 -> 28 - 1 = 27.0
        for (int i = 0; i < WIDTH; i++) begin
            in_data[i] = 32'(i) << 16;
            weights[i] = 32'h0001_0000;
        end
        issue(32'hFFFF_0000, 8'h17, 32'h001B_0000);
        wait_idle();

        set_all(32'hFFFF_0000, 32'h0001_0000);
`ifdef IP_FWD_RELU_EN
        issue(32'h0, 8'h01, 32'h0000_0000);
`else
        issue(32'h0, 8'h01, 32'hFFF8_0000);
`endif
        wait_idle();

        set_all(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        issue(32'h7FFF_FFFF, 8'h02, 32'h7FFF_FFFF);
        wait_idle();

        set_all(32'h7FFF_FFFF, 32'h8000_0000);
`ifdef IP_FWD_RELU_EN
        issue(32'h7FFF_FFFF, 8'h03, 32'h0000_0000);
`else
        issue(32'h7FFF_FFFF, 8'h03, 32'h8000_0000);
`endif
        wait_idle();

        // 2^-16 * 0.5 floors to 0; -2^-16 * 0.5 floors to -2^-16
        set_all(32'h0, 32'h0);
        in_data[0] = 32'h0000_0001;
        weights[0] = 32'h0000_8000;
        issue(32'h0, 8'h04, 32'h0000_0000);
        wait_idle();
        set_all(32'h0, 32'h0);
        in_data[0] = 32'hFFFF_FFFF;
        weights[0] = 32'h0000_8000;
`ifdef IP_FWD_RELU_EN
        issue(32'h0, 8'h05, 32'h0000_0000);
`else
        issue(32'h0, 8'h05, 32'hFFFF_FFFF);
`endif
        wait_idle();

        // Backpressure: stall 5 cycles with a spurious in_valid, then back-to-back accept
        out_ready = 1'b0;
        set_all(32'h0001_0000, 32'h0002_0000);
        issue(32'h0000_8000, 8'h33, 32'h0010_8000);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                total++;
                bad++;
                $display("FAIL bp_valid_timeout actual out_valid=0 required out_valid=1");
            end
        end
        set_all(32'h1234_5678, 32'h1234_5678);
        bias     = 32'h1111_1111;
        in_id    = 8'hEE;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        set_all(32'h0001_0000, 32'h0001_0000);
        bias  = 32'h0;
        in_id = 8'h44;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_after_hs", 64'(in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", 64'(in_ready), 64'(0));
        sb.push_back('{data: 32'h0008_0000, id: 8'h44, due: cyc + LAT});
        in_valid = 1'b0;
        set_all(32'hDEADBEEF, 32'hDEADBEEF);
        wait_idle();

        // Reset in the middle of MAC (idx = 3)
        set_all(32'h0001_0000, 32'h0003_0000);
        issue(32'h0, 8'h11, 32'h0018_0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out_data", 64'(out_data), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready_up", 64'(in_ready), 64'(1));
        set_all(32'h0001_0000, 32'h0001_0000);
        issue(32'h0, 8'h22, 32'h0008_0000);
        wait_idle();

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ip_forward_seq.md
Name: ip_forward_seq

Overview:
Sequential fully-connected forward engine, the forward-pass counterpart of ip_backward. It accepts one input vector, weight vector, bias and tag per transaction over a valid/ready handshake. It computes out = sum(in_data[i]*weights[i]) + bias using a single multiply-accumulate datapath iterated over WIDTH cycles. The result is returned with its tag on a valid/ready output handshake. Arithmetic is signed fixed-point Q(DATA_W-FRAC_BITS).FRAC_BITS.

Parameters:
WIDTH, 8, vector length (>=2).
DATA_W, 32, bit width of every data/weight/bias/result word (two's complement).
FRAC_BITS, 16, fractional bits of the fixed-point format.
ID_W, 8, tag width.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input transaction present
in_ready  output  1  block can accept a transaction
in_data  input  DATA_W x WIDTH  unpacked input vector
weights  input  DATA_W x WIDTH  unpacked weight vector
bias  input  DATA_W  bias term
in_id  input  ID_W  transaction tag
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
out_data  output  DATA_W  result
out_id  output  ID_W  tag of result

Behaviour:
- States: IDLE, MAC, BIAS, DONE. Reset (asserted at any time, including mid-MAC or during DONE) forces IDLE immediately. Reset values: in_ready=0 while reset is high, then 1 in IDLE; out_valid=0; out_data=0; out_id=0; accumulator=0; index=0.
- IDLE: in_ready=1. An accept happens on a rising edge with in_valid&&in_ready. At accept, in_data, weights, bias and in_id are captured into internal registers, the accumulator and index are cleared, and the state moves to MAC. Inputs may change after the accept without effect.
- MAC: one element per cycle. acc += in_r[idx]*w_r[idx], using a full 2*DATA_W signed product. The accumulator is 2*DATA_W+clog2(WIDTH) bits, so it never overflows. idx increments each cycle; after idx=WIDTH-1 the state moves to BIAS.
- BIAS: sum = acc + (sign-extended bias << FRAC_BITS). The result is sum arithmetically shifted right by FRAC_BITS (floor rounding toward -inf), then saturated to the signed DATA_W range [0x80..0, 0x7F..F]. The result and tag are loaded into out_data/out_id, out_valid is set, and the state moves to DONE.
- Latency: for an accept at edge k, out_valid is high after edge k+WIDTH+1 (9 cycles for WIDTH=8).
- DONE: out_valid=1; out_data and out_id are held stable until out_valid&&out_ready. On that edge out_valid drops and the state returns to IDLE. The earliest next accept is the following edge; there is no overlap of transactions.
- in_ready=0 in MAC, BIAS and DONE. in_valid asserted in those states is ignored and not queued.
- out_data keeps its last value after a handshake. Only out_valid qualifies it.

Optional Feature:
Macro IP_FWD_RELU_EN.
- Defined: ReLU is applied in the BIAS stage after saturation; a negative result becomes 0. Latency is unchanged.
- Undefined: the saturated value is output unmodified.

Test Plan:
- Basic: all in=0x00010000 (1.0), all w=0x00020000 (2.0), bias=0x00008000, id=0x5A. Required: out_data=0x00108000 (16.5), out_id=0x5A, out_valid high exactly WIDTH+1 edges after accept.
- Negative/ReLU: all in=0xFFFF0000 (-1.0), all w=0x00010000, bias=0. Required: out_data=0xFFF80000. With IP_FWD_RELU_EN defined: out_data=0x00000000.
- Saturation: all in=0x7FFFFFFF, all w=0x7FFFFFFF, bias=0x7FFFFFFF. Required: out_data=0x7FFFFFFF. The same inputs with weights=0x80000000 give out_data=0x80000000, or 0 under ReLU.
- Floor rounding: in[0]=0x00000001, w[0]=0x00008000, all other elements and bias zero. Required: out_data=0x00000000. Then in[0]=0xFFFFFFFF with the same weights. Required: out_data=0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: out_data and out_id stable, in_ready=0, and a new in_valid is not accepted. After out_ready=1, the next transaction is accepted on the following edge with correct result.
- Reset mid-operation: assert reset at MAC idx=3. Required: out_valid=0, out_data=0 and in_ready=0 immediately (asynchronous), with in_ready=1 on the first edge after deassert. A fresh transaction then yields the correct result with no residue from the aborted one.
